uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised UART receiver, successor to the fixed 8N1 UART_RX.
//  Configurable data width, stop bits and oversampling; 3-sample majority vote;
//  false-start rejection; framing-error reporting; optional parity check.
//  Sits on the serial line opposite UART_TX; feeds bytes to the host logic.
// PARAMETERS
//  CLKS_PER_BIT  434  clk cycles per bit (50 MHz / 115200); must be >= 8
//  DATA_BITS     8    data bits per frame, 5..9, LSB first
//  STOP_BITS     1    stop bits checked, 1 or 2
//  PARITY_ODD    0    0 = even parity, 1 = odd; used only with UART_RX_PARITY_EN
// PORTS
//  clk            in   1          system clock
//  rst_n          in   1          async reset, active low
//  rx_serial      in   1          asynchronous serial input, idle high
//  rx_byte        out  DATA_BITS  last good word; held until next rx_dv
//  rx_dv          out  1          one-cycle pulse: rx_byte valid
//  rx_frame_err   out  1          one-cycle pulse: stop bit sampled low
//  rx_parity_err  out  1          valid with rx_dv; parity mismatch
//  rx_busy        out  1          high whenever state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0; synchroniser flops 1; state IDLE; counters 0.
//  rx_serial passes a 2-flop synchroniser (rx_s); all logic below uses rx_s.
//  M = CLKS_PER_BIT/2 (integer). Bit value = majority of rx_s at counts
//   M-1, M, M+1 within each bit period; bit counter resets at CLKS_PER_BIT-1.
//  States: IDLE, START, DATA, PARITY, STOP, BREAK.
//  IDLE: rx_s == 0 -> START, count cleared.
//  START: at count M+1, vote = 1 -> IDLE (false start, no pulses);
//   vote = 0 -> DATA, then data bits sampled at whole-bit intervals.
//  DATA: shift DATA_BITS votes LSB first; after last -> PARITY (macro) or STOP.
//  PARITY: vote compared with XOR(data) ^ PARITY_ODD -> STOP.
//  STOP: each of STOP_BITS sampled; any 0 vote -> rx_frame_err pulse 1 cycle,
//   no rx_dv, rx_byte unchanged, -> BREAK.
//   All stop bits 1: rx_byte loaded, rx_dv pulse 1 cycle, -> IDLE at
//   count M+2 of last stop bit (next start edge detectable from mid-stop on).
//  BREAK: wait for rx_s == 1, then -> IDLE (no repeated errors on long break).
//  Latency: rx_dv rises exactly 2 + (1+DATA_BITS+P+STOP_BITS-1)*CLKS_PER_BIT
//   + M + 2 clk after the rx_serial falling edge (P = 1 with parity, else 0).
//  Back-to-back frames with zero idle must all be received.
//  rx_dv and rx_frame_err never high together.
//  rst_n low mid-frame: immediate return to reset state; partial word discarded.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: frame carries one parity bit after data; PARITY
//   state used; rx_parity_err = 1 with rx_dv on mismatch (word still delivered).
//  Not defined: no parity bit in frame, PARITY state never entered,
//   rx_parity_err tied 0; port list unchanged.
// TESTING (CLKS_PER_BIT=16, clk 20 ns, TX driven by bench BFM)
//  1. 8N1 byte 0x4B -> single rx_dv, rx_byte=8'h4B, both errs 0, latency per formula.
//  2. rx_serial low 3 clk then high -> no rx_dv/rx_frame_err, rx_busy back to 0.
//  3. 0x00 with stop bit low, line low 40 bits -> one rx_frame_err, no rx_dv,
//     rx_byte keeps prior 8'h4B; after line high, 0x5A received correctly.
//  4. 0x55 then 0xAA, zero idle gap -> two rx_dv pulses, 8'h55 then 8'hAA.
//  5. UART_RX_PARITY_EN, PARITY_ODD=0: 0x4B parity 0 -> rx_dv, parity_err 0;
//     0x4B parity 1 -> rx_dv, rx_byte=8'h4B, rx_parity_err 1.
//  6. rst_n low during data bit 3 of 0xFF -> outputs 0 immediately;
//     after release, 0xC3 -> rx_dv, rx_byte=8'hC3.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote, false-start
// rejection, framing-error reporting. Optional parity check when UART_RX_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low
// START  | start bit; mid-bit vote confirms or rejects it
// DATA   | shifting DATA_BITS voted bits, LSB first
// PARITY | parity bit vote (UART_RX_PARITY_EN only)
// STOP   | checking STOP_BITS stop bits
// BREAK  | framing error seen; wait for line to return high
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 rx_dv,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int M  = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_LO   = CW'(M - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(M);
    localparam logic [CW-1:0] CNT_HI   = CW'(M + 1);
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 8 || DATA_BITS < 5 || DATA_BITS > 9 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_rx_cfg: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t               state, state_n;
    logic                 rx_meta, rx_s;
    logic [CW-1:0]        cnt, cnt_n, cnt_inc;
    logic [3:0]           bit_idx, bit_idx_n;
    logic                 stop_idx, stop_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 smp_a, smp_a_n, smp_b, smp_b_n;
    logic [DATA_BITS-1:0] byte_n;
    logic                 dv_n, ferr_n;
    logic                 vote, at_vote;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rx_s    <= rx_meta;
        end
    end

    // Third vote sample is the live rx_s at count M+1.
    assign vote    = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
    assign at_vote = (cnt == CNT_HI);
    assign cnt_inc = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    assign rx_busy = (state != IDLE);

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic par_bad, par_bad_n, perr_n;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            shreg        <= '0;
            smp_a        <= 1'b0;
            smp_b        <= 1'b0;
            rx_byte      <= '0;
            rx_dv        <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            bit_idx      <= bit_idx_n;
            stop_idx     <= stop_idx_n;
            shreg        <= shreg_n;
            smp_a        <= smp_a_n;
            smp_b        <= smp_b_n;
            rx_byte      <= byte_n;
            rx_dv        <= dv_n;
            rx_frame_err <= ferr_n;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad       <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            par_bad       <= par_bad_n;
            rx_parity_err <= perr_n;
        end
    end
`else
    assign rx_parity_err = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        cnt_n      = cnt_inc;
        bit_idx_n  = bit_idx;
        stop_idx_n = stop_idx;
        shreg_n    = shreg;
        smp_a_n    = (cnt == CNT_LO)  ? rx_s : smp_a;
        smp_b_n    = (cnt == CNT_MID) ? rx_s : smp_b;
        byte_n     = rx_byte;
        dv_n       = 1'b0;
        ferr_n     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n  = par_bad;
        perr_n     = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_n      = '0;
                bit_idx_n  = '0;
                stop_idx_n = 1'b0;
`ifdef UART_RX_PARITY_EN
                par_bad_n  = 1'b0;
`endif
                if (!rx_s) state_n = START;
            end
            START: begin
                if (at_vote) state_n = vote ? IDLE : DATA;
            end
            DATA: begin
                if (at_vote) begin
                    shreg_n   = {vote, shreg[DATA_BITS-1:1]};
                    bit_idx_n = bit_idx + 4'd1;
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (at_vote) begin
                    par_bad_n = vote ^ (^shreg) ^ PAR_ODD;
                    state_n   = STOP;
                end
            end
`endif
            STOP: begin
                if (at_vote) begin
                    if (!vote) begin
                        ferr_n  = 1'b1;
                        state_n = BREAK;
                    end else if (stop_idx == LAST_STOP) begin
                        // Leave at count M+2 so a start edge right after mid-stop is caught.
                        byte_n  = shreg;
                        dv_n    = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_n  = par_bad;
`endif
                        state_n = IDLE;
                    end else begin
                        stop_idx_n = 1'b1;
                    end
                end
            end
            BREAK: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: serial BFM drives frames, a scoreboard queue
// holds expected words, a negedge monitor pops and compares on every rx_dv.
module tb_uart_rx_cfg;

    localparam int CPB        = 16;
    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int PARITY_ODD = 0;
    localparam int M          = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int EXP_LAT = 2 + (1 + DATA_BITS + P + STOP_BITS - 1) * CPB + M + 2;

    logic       clk;
    logic       rst_n;
    logic       rx_serial;
    logic [7:0] rx_byte;
    logic       rx_dv;
    logic       rx_frame_err;
    logic       rx_parity_err;
    logic       rx_busy;

    typedef struct {
        logic [7:0] data;
        logic       perr;
    } exp_t;

    exp_t   sb[$];
    int     checks   = 0;
    int     failures = 0;
    int     dv_cnt   = 0;
    int     ferr_cnt = 0;
    longint t_drive  = 0;
    longint last_lat = 0;

    uart_rx_cfg #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DATA_BITS),
        .STOP_BITS   (STOP_BITS),
        .PARITY_ODD  (PARITY_ODD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_serial    (rx_serial),
        .rx_byte      (rx_byte),
        .rx_dv        (rx_dv),
        .rx_frame_err (rx_frame_err),
        .rx_parity_err(rx_parity_err),
        .rx_busy      (rx_busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_serial = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par_flip);
        exp_t e;
        e.data = data;
        e.perr = par_flip;
        sb.push_back(e);
        t_drive = $time;
        send_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^data) ^ 1'(PARITY_ODD) ^ par_flip);
`endif
        for (int i = 0; i < STOP_BITS; i++) send_bit(1'b1);
    endtask

    // Line is driven at a negedge; the first posedge samples it 10 units later and the
    // rx_dv rise is observed at the negedge after its posedge, hence the 20-unit offset.
    always @(negedge clk) begin
        exp_t e;
        if (rx_dv || rx_frame_err)
            chk("dv_ferr_excl", {31'b0, rx_dv & rx_frame_err}, 32'd0);
        if (rx_frame_err) ferr_cnt++;
        if (rx_dv) begin
            dv_cnt++;
            last_lat = ($time - t_drive - 20) / 20;
            if (sb.size() == 0) begin
                chk("dv_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rx_byte", {24'b0, rx_byte}, {24'b0, e.data});
                chk("rx_parity_err", {31'b0, rx_parity_err}, {31'b0, e.perr});
            end
        end
    end

    initial begin
        int dv0, fe0;
        rst_n     = 1'b0;
        rx_serial = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_byte", {24'b0, rx_byte}, 32'd0);
        chk("rst_dv", {31'b0, rx_dv}, 32'd0);
        chk("rst_ferr", {31'b0, rx_frame_err}, 32'd0);
        chk("rst_perr", {31'b0, rx_parity_err}, 32'd0);
        chk("rst_busy", {31'b0, rx_busy}, 32'd0);
        rst_n = 1'b1;
        repeat (CPB) @(negedge clk);

        // single 8N1 word with latency
        send_frame(8'h4B, 1'b0);
        repeat (CPB) @(negedge clk);
        chk("t1_dv_cnt", dv_cnt, 32'd1);
        chk("t1_ferr_cnt", ferr_cnt, 32'd0);
        chk("t1_latency", 32'(last_lat), 32'(EXP_LAT));
        chk("t1_busy", {31'b0, rx_busy}, 32'd0);

        // 3-clock glitch is rejected as a false start
        dv0 = dv_cnt;
        fe0 = ferr_cnt;
        rx_serial = 1'b0;
        repeat (3) @(negedge clk);
        rx_serial = 1'b1;
        chk("t2_busy_start", {31'b0, rx_busy}, 32'd1);
        repeat (2 * CPB) @(negedge clk);
        chk("t2_busy_idle", {31'b0, rx_busy}, 32'd0);
        chk("t2_no_dv", dv_cnt, dv0);
        chk("t2_no_ferr", ferr_cnt, fe0);

        // long break: one framing error, word held, then recovery
        dv0 = dv_cnt;
        fe0 = ferr_cnt;
        rx_serial = 1'b0;
        repeat (40 * CPB) @(negedge clk);
        chk("t3_busy_break", {31'b0, rx_busy}, 32'd1);
        rx_serial = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk("t3_ferr_once", ferr_cnt, fe0 + 1);
        chk("t3_no_dv", dv_cnt, dv0);
        chk("t3_byte_hold", {24'b0, rx_byte}, 32'h4B);
        chk("t3_busy_idle", {31'b0, rx_busy}, 32'd0);
        send_frame(8'h5A, 1'b0);
        repeat (CPB) @(negedge clk);
        chk("t3_dv_after", dv_cnt, dv0 + 1);

        // back-to-back frames, zero idle
        dv0 = dv_cnt;
        send_frame(8'h55, 1'b0);
        send_frame(8'hAA, 1'b0);
        repeat (CPB) @(negedge clk);
        chk("t4_dv_cnt", dv_cnt, dv0 + 2);
        chk("t4_last_byte", {24'b0, rx_byte}, 32'hAA);

`ifdef UART_RX_PARITY_EN
        dv0 = dv_cnt;
        send_frame(8'h4B, 1'b0);
        send_frame(8'h4B, 1'b1);
        repeat (CPB) @(negedge clk);
        chk("t5_dv_cnt", dv_cnt, dv0 + 2);
`endif

        // reset during data bit 3 of 0xFF
        dv0 = dv_cnt;
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clk);
        rx_serial = 1'b1;
        repeat (3 * CPB + CPB / 2) @(negedge clk);
        chk("t6_busy_pre", {31'b0, rx_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_byte", {24'b0, rx_byte}, 32'd0);
        chk("t6_rst_busy", {31'b0, rx_busy}, 32'd0);
        chk("t6_rst_dv", {31'b0, rx_dv}, 32'd0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (CPB) @(negedge clk);
        send_frame(8'hC3, 1'b0);
        repeat (CPB) @(negedge clk);
        chk("t6_dv_cnt", dv_cnt, dv0 + 1);
        chk("t6_byte", {24'b0, rx_byte}, 32'hC3);

        chk("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
